// File: rtl/sensor_poll_scheduler.sv
// Command sequencer and poll arbiter for the shared single-wire sensor reader.
// Optional WAIT watchdog is built when SENS_TIMEOUT_EN is defined.
module sensor_poll_scheduler #(
    parameter int ADDR_W   = 3,
    parameter int TICK_DIV = 50000000,
    parameter int TIMEOUT  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_code,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              sens_req,
    output logic [ADDR_W-1:0] sens_addr,
    output logic [1:0]        sens_kind,
    input  logic              sens_done,
    input  logic              sens_ok,
    input  logic [7:0]        sens_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_code,
    output logic [7:0]        rsp_data,
    output logic [ADDR_W-1:0] rsp_addr
);

    localparam int NumSens  = 1 << ADDR_W;
    localparam int NumSlots = 2 * NumSens;
    localparam int SlotW    = ADDR_W + 1;
    localparam int CntW     = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [NumSens-1:0]  tempEn_q, tempEn_d;
    logic [NumSens-1:0]  humEn_q, humEn_d;
    logic [NumSlots-1:0] roundMask_q, roundMask_d;
    logic [CntW-1:0]     tickCnt_q, tickCnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          kind_q, kind_d;
    logic [7:0]          okCode_q, okCode_d;
    logic [7:0]          rspCode_q, rspCode_d;
    logic [7:0]          rspData_q, rspData_d;

    logic [NumSlots-1:0] enSlots;
    logic [NumSlots-1:0] pending;
    logic                slotFound;
    logic [SlotW-1:0]    slotIdx;
    logic                tick;
    logic                timeoutHit;

`ifdef SENS_TIMEOUT_EN
    localparam int TmrW = $clog2(TIMEOUT + 1);
    logic [TmrW-1:0] waitCnt_q, waitCnt_d;

    always_comb begin
        waitCnt_d = '0;
        if (state_q == WAIT) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    assign timeoutHit = (state_q == WAIT) && (waitCnt_q == TmrW'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the watchdog is built.
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT != 0);
    assign timeoutHit    = 1'b0;
`endif

    // Slot order is temp0, hum0, temp1, hum1, ... so even bits are temperature.
    always_comb begin
        enSlots = '0;
        for (int a = 0; a < NumSens; a++) begin
            enSlots[2*a]   = tempEn_q[a];
            enSlots[2*a+1] = humEn_q[a];
        end
    end

    assign pending = roundMask_q & enSlots;

    always_comb begin
        slotFound = 1'b0;
        slotIdx   = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (pending[i]) begin
                slotFound = 1'b1;
                slotIdx   = SlotW'(i);
            end
        end
    end

    assign tick = (tickCnt_q == '0);

    always_comb begin
        state_d     = state_q;
        tempEn_d    = tempEn_q;
        humEn_d     = humEn_q;
        addr_d      = addr_q;
        kind_d      = kind_q;
        okCode_d    = okCode_q;
        rspCode_d   = rspCode_q;
        rspData_d   = rspData_q;
        tickCnt_d   = tick ? CntW'(TICK_DIV - 1) : tickCnt_q - 1'b1;
        // Dropping disabled slots here makes mid-round stops skip their poll.
        roundMask_d = tick ? enSlots : pending;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    unique case (cmd_code)
                        3'b000: begin kind_d = 2'b00; okCode_d = 8'h1F; state_d = ISSUE; end
                        3'b010: begin kind_d = 2'b01; okCode_d = 8'h09; state_d = ISSUE; end
                        3'b011: begin kind_d = 2'b10; okCode_d = 8'h08; state_d = ISSUE; end
                        3'b110: begin
                            tempEn_d[cmd_addr] = 1'b1;
                            kind_d   = 2'b01;
                            okCode_d = 8'h0C;
                            state_d  = ISSUE;
                        end
                        3'b111: begin
                            humEn_d[cmd_addr] = 1'b1;
                            kind_d   = 2'b10;
                            okCode_d = 8'h0D;
                            state_d  = ISSUE;
                        end
                        3'b100: begin
                            tempEn_d[cmd_addr] = 1'b0;
                            rspCode_d = 8'h0A;
                            rspData_d = 8'h00;
                            state_d   = RESP;
                        end
                        3'b101: begin
                            humEn_d[cmd_addr] = 1'b0;
                            rspCode_d = 8'h0B;
                            rspData_d = 8'h00;
                            state_d   = RESP;
                        end
                        default: begin
                            rspCode_d = 8'hFF;
                            rspData_d = 8'h00;
                            state_d   = RESP;
                        end
                    endcase
                end else if (slotFound) begin
                    addr_d   = slotIdx[SlotW-1:1];
                    kind_d   = slotIdx[0] ? 2'b10 : 2'b01;
                    okCode_d = slotIdx[0] ? 8'h0D : 8'h0C;
                    if (!tick) begin
                        roundMask_d[slotIdx] = 1'b0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (sens_done) begin
                    rspCode_d = sens_ok ? okCode_q : 8'h07;
                    rspData_d = sens_ok ? sens_data : 8'h00;
                    state_d   = RESP;
                end else if (timeoutHit) begin
                    rspCode_d = 8'h07;
                    rspData_d = 8'h00;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tempEn_q    <= '0;
            humEn_q     <= '0;
            roundMask_q <= '0;
            tickCnt_q   <= CntW'(TICK_DIV - 1);
            addr_q      <= '0;
            kind_q      <= '0;
            okCode_q    <= '0;
            rspCode_q   <= '0;
            rspData_q   <= '0;
        end else begin
            state_q     <= state_d;
            tempEn_q    <= tempEn_d;
            humEn_q     <= humEn_d;
            roundMask_q <= roundMask_d;
            tickCnt_q   <= tickCnt_d;
            addr_q      <= addr_d;
            kind_q      <= kind_d;
            okCode_q    <= okCode_d;
            rspCode_q   <= rspCode_d;
            rspData_q   <= rspData_d;
        end
    end

    // Gating with rst keeps cmd_ready low while reset is held.
    assign cmd_ready = (state_q == IDLE) && rst;
    assign sens_req  = (state_q == ISSUE);
    assign sens_addr = addr_q;
    assign sens_kind = kind_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_code  = rspCode_q;
    assign rsp_data  = rspData_q;
    assign rsp_addr  = addr_q;

endmodule
